audio_fx_engine: RTL

//  Parametrised successor to the fixed 16-bit tone/pass-through effects block; sits between codec RX/TX sample strobes.

---
 rtl/audio_fx_pkg.sv | 47 ++++
 rtl/audio_fx_engine_if.sv | 22 ++
 rtl/audio_delay_line.sv | 44 ++++
 rtl/audio_fx_engine.sv | 101 ++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
// Shared mode encodings and arithmetic helpers for the audio effects engine.
// sine_word builds the tone table at elaboration; sat_add clamps a widened sum.
package audio_fx_pkg;

    typedef enum logic [3:0] {
        MODE_SILENT   = 4'b0000,
        MODE_SINE     = 4'b0001,
        MODE_FEEDBACK = 4'b0011,
        MODE_ECHO     = 4'b0111
    } fx_mode_e;

    localparam int SAT_W = 32;

    // Adds two sign-extended samples and clamps the result to a w-bit two's complement range.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sum = (SAT_W+1)'(a) + (SAT_W+1)'(b);
        hi  = (SAT_W+1)'((64'sd1 <<< (w - 1)) - 64'sd1);
        lo  = -hi - (SAT_W+1)'(1);
        if (sum > hi)      return hi[SAT_W-1:0];
        else if (sum < lo) return lo[SAT_W-1:0];
        else               return sum[SAT_W-1:0];
    endfunction

    // Bhaskara sine approximation over one period of 'depth' entries, full-scale 'width'-bit amplitude.
    function automatic longint sine_word(input int idx, input int depth, input int width);
        longint half;
        longint q;
        longint t;
        longint amp;
        longint mag;
        half = longint'(depth / 2);
        q    = longint'(idx);
        if (q >= half) q = q - half;
        t    = q * (half - q);
        amp  = (longint'(1) <<< (width - 1)) - 1;
        mag  = (amp * 16 * t) / (5 * half * half - 4 * t);
        return (longint'(idx) >= half) ? -mag : mag;
    endfunction

endpackage

// File: rtl/audio_fx_engine_if.sv
// Codec-side strobes, sample buses and mode controls of the effects engine.
interface audio_fx_engine_if #(
    parameter int DATA_W = 16,
    parameter int STEP_W = 7
);
    logic              sample_end;
    logic              sample_req;
    logic [DATA_W-1:0] audio_input;
    logic [DATA_W-1:0] audio_output;
    logic [3:0]        control;
    logic [STEP_W-1:0] tone_step;

    modport master (
        output sample_end, sample_req, audio_input, control, tone_step,
        input  audio_output
    );

    modport slave (
        input  sample_end, sample_req, audio_input, control, tone_step,
        output audio_output
    );
endinterface

// File: rtl/audio_delay_line.sv
// Circular echo delay line: read-before-write at wptr on every write strobe,
// tap_valid marks that the word just read was written DELAY_DEPTH writes ago.
module audio_delay_line #(
    parameter int DATA_W      = 16,
    parameter int DELAY_DEPTH = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              tap_valid
);
    localparam int ADDR_W = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 1;

    logic [DATA_W-1:0] mem [DELAY_DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   fill;
    logic              full;

    assign full = (fill == (ADDR_W+1)'(DELAY_DEPTH));

    // NOTE: the RAM and its read register carry no reset so they map onto block RAM; stale words are masked by tap_valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rd_data   <= mem[wptr];
            mem[wptr] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr      <= '0;
            fill      <= '0;
            tap_valid <= 1'b0;
        end else if (wr_en) begin
            wptr      <= wptr + 1'b1;
            tap_valid <= full;
            if (!full) fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/audio_fx_engine.sv
// Audio effects engine: silence, DDS sine table walk, pass-through and optional echo.
// Define AUDIO_FX_ECHO_EN to build the delay line; otherwise MODE_ECHO behaves as MODE_FEEDBACK.
module audio_fx_engine
    import audio_fx_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int TABLE_DEPTH = 100,
    parameter int STEP_W      = 7,
    parameter int DELAY_DEPTH = 4096,
    parameter int ECHO_SHIFT  = 1
) (
    input logic               clk,
    input logic               reset_n,
    audio_fx_engine_if.slave  bus
);
    localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
    localparam int SUM_W = ((IDX_W > STEP_W) ? IDX_W : STEP_W) + 1;

    logic [DATA_W-1:0] rom [TABLE_DEPTH];
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out_next;
    logic [DATA_W-1:0] last_sample;
    logic [DATA_W-1:0] echo_mix;
    logic [IDX_W-1:0]  sine_idx;
    logic              idx_adv;
    logic [SUM_W-1:0]  step_eff;
    logic [SUM_W-1:0]  idx_sum;
    logic [SUM_W-1:0]  idx_next;

    for (genvar i = 0; i < TABLE_DEPTH; i++) begin : g_rom
        assign rom[i] = DATA_W'(sine_word(i, TABLE_DEPTH, DATA_W));
    end

    // Index stays below TABLE_DEPTH, so one conditional subtract completes the modulo.
    always_comb begin
        step_eff = SUM_W'(bus.tone_step);
        if (step_eff >= SUM_W'(TABLE_DEPTH)) step_eff = SUM_W'(TABLE_DEPTH - 1);
        idx_sum  = SUM_W'(sine_idx) + step_eff;
        idx_next = (idx_sum >= SUM_W'(TABLE_DEPTH)) ? idx_sum - SUM_W'(TABLE_DEPTH) : idx_sum;
    end

`ifdef AUDIO_FX_ECHO_EN
    logic [DATA_W-1:0]        tap_data;
    logic                     tap_valid;
    logic signed [DATA_W-1:0] tap_s;
    logic signed [DATA_W-1:0] live_s;

    audio_delay_line #(
        .DATA_W      (DATA_W),
        .DELAY_DEPTH (DELAY_DEPTH)
    ) u_delay (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (bus.sample_end & reset_n),
        .wr_data   (bus.audio_input),
        .rd_data   (tap_data),
        .tap_valid (tap_valid)
    );

    always_comb begin
        live_s   = last_sample;
        tap_s    = tap_valid ? (signed'(tap_data) >>> ECHO_SHIFT) : '0;
        echo_mix = DATA_W'(sat_add(SAT_W'(live_s), SAT_W'(tap_s), DATA_W));
    end
`else
    assign echo_mix = last_sample;
`endif

    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        out_next = out_q;
        idx_adv  = 1'b0;
        case (bus.control)
            MODE_SILENT:   out_next = '0;
            MODE_SINE: begin
                out_next = rom[sine_idx];
                idx_adv  = 1'b1;
            end
            MODE_FEEDBACK: out_next = last_sample;
            MODE_ECHO:     out_next = echo_mix;
            default:       ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q       <= '0;
            last_sample <= '0;
            sine_idx    <= '0;
        end else begin
            if (bus.sample_end) last_sample <= bus.audio_input;
            if (bus.sample_req) begin
                out_q <= out_next;
                if (idx_adv) sine_idx <= IDX_W'(idx_next);
            end
        end
    end

    assign bus.audio_output = out_q;

endmodule
